scr1_imem_fetch_tracer: RTL and testbench

// Passive tap on the core imem interface, downstream of the imem AHB bridge. Pairs each

---
 rtl/scr1_imem_fetch_tracer.sv | 162 ++++++++++++++++
 tb/tb_scr1_imem_fetch_tracer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_imem_fetch_tracer.sv
// Passive imem fetch tracer: pairs accepted fetch addresses with their
// responses, classifies ADDI instructions, queues trace records in a
// show-ahead FIFO and keeps saturating statistics counters and sticky flags.
module scr1_imem_fetch_tracer #(
   parameter int unsigned PEND_DEPTH  = 4,
   parameter int unsigned TRACE_DEPTH = 8,
   parameter int unsigned CNT_W       = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              imem_req,
   input  logic              imem_req_ack,
   input  logic [31:0]       imem_addr,
   input  logic [1:0]        imem_resp,
   input  logic [31:0]       imem_rdata,
   input  logic              cnt_clr,
   output logic              trace_valid,
   input  logic              trace_ready,
   output logic [31:0]       trace_addr,
   output logic [31:0]       trace_instr,
   output logic              trace_err,
   output logic              trace_is_addi,
   output logic [CNT_W-1:0]  cnt_fetch,
   output logic [CNT_W-1:0]  cnt_addi,
   output logic [CNT_W-1:0]  cnt_drop,
   output logic              pend_overflow,
   output logic              orphan_resp
);

   localparam int unsigned PW = $clog2(PEND_DEPTH);
   localparam int unsigned TW = $clog2(TRACE_DEPTH);

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] instr;
      logic        err;
      logic        is_addi;
   } rec_t;

   // Pending-address FIFO state
   logic [PW:0]  pwr_q, pwr_d, prd_q, prd_d;
   logic [31:0]  pmem_q [PEND_DEPTH];

   // Trace record FIFO state
   logic [TW:0]  twr_q, twr_d, trd_q, trd_d;
   rec_t         tmem_q [TRACE_DEPTH];

   // Statistics
   logic [CNT_W-1:0] cnt_fetch_q, cnt_fetch_d;
   logic [CNT_W-1:0] cnt_addi_q,  cnt_addi_d;
   logic [CNT_W-1:0] cnt_drop_q,  cnt_drop_d;
   logic             ovf_q, ovf_d, orph_q, orph_d;

   logic accept, resp_v;
   logic pend_empty, pend_full, pend_push, pend_pop;
   logic tr_empty, tr_full, tr_push, tr_pop, tr_drop;
   rec_t new_rec, head_rec;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Handshake decode, record formation and FIFO control
   always_comb begin
      accept     = imem_req & imem_req_ack;
      resp_v     = |imem_resp;

      pend_empty = (pwr_q == prd_q);
      pend_full  = (pwr_q[PW] != prd_q[PW]) && (pwr_q[PW-1:0] == prd_q[PW-1:0]);
      // The response pops the existing head first, so a full FIFO can still
      // take the address accepted in the same cycle.
      pend_pop   = resp_v & ~pend_empty;
      pend_push  = accept & (~pend_full | pend_pop);

      tr_empty   = (twr_q == trd_q);
      tr_full    = (twr_q[TW] != trd_q[TW]) && (twr_q[TW-1:0] == trd_q[TW-1:0]);
      tr_pop     = ~tr_empty & trace_ready;
      tr_push    = pend_pop & (~tr_full | tr_pop);
      tr_drop    = pend_pop & tr_full & ~tr_pop;

      new_rec         = '0;
      new_rec.addr    = pmem_q[prd_q[PW-1:0]];
      new_rec.err     = imem_resp[1];
      new_rec.instr   = imem_resp[1] ? '0 : imem_rdata;
      new_rec.is_addi = (imem_resp == 2'b01) && (imem_rdata[6:0] == 7'b0010011)
                        && (imem_rdata[14:12] == 3'b000);

      pwr_d = pwr_q + (PW+1)'(pend_push);
      prd_d = prd_q + (PW+1)'(pend_pop);
      twr_d = twr_q + (TW+1)'(tr_push);
      trd_d = trd_q + (TW+1)'(tr_pop);
   end

   // Counter and sticky-flag next state; clear has priority over updates
   always_comb begin
      cnt_fetch_d = cnt_fetch_q;
      cnt_addi_d  = cnt_addi_q;
      cnt_drop_d  = cnt_drop_q;
      ovf_d       = ovf_q;
      orph_d      = orph_q;
      if (cnt_clr) begin
         cnt_fetch_d = '0;
         cnt_addi_d  = '0;
         cnt_drop_d  = '0;
         ovf_d       = 1'b0;
         orph_d      = 1'b0;
      end else begin
         if (pend_pop)                   cnt_fetch_d = sat_inc(cnt_fetch_q);
         if (pend_pop & new_rec.is_addi) cnt_addi_d  = sat_inc(cnt_addi_q);
         if (tr_drop)                    cnt_drop_d  = sat_inc(cnt_drop_q);
         if (accept & pend_full & ~pend_pop) ovf_d   = 1'b1;
         if (resp_v & pend_empty)        orph_d      = 1'b1;
      end
   end

   // Pointers, counters and flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwr_q       <= '0;
         prd_q       <= '0;
         twr_q       <= '0;
         trd_q       <= '0;
         cnt_fetch_q <= '0;
         cnt_addi_q  <= '0;
         cnt_drop_q  <= '0;
         ovf_q       <= 1'b0;
         orph_q      <= 1'b0;
      end else begin
         pwr_q       <= pwr_d;
         prd_q       <= prd_d;
         twr_q       <= twr_d;
         trd_q       <= trd_d;
         cnt_fetch_q <= cnt_fetch_d;
         cnt_addi_q  <= cnt_addi_d;
         cnt_drop_q  <= cnt_drop_d;
         ovf_q       <= ovf_d;
         orph_q      <= orph_d;
      end
   end

   // FIFO storage; contents are don't-care until pointers make them visible
   always_ff @(posedge clk) begin
      if (pend_push) pmem_q[pwr_q[PW-1:0]] <= imem_addr;
      if (tr_push)   tmem_q[twr_q[TW-1:0]] <= new_rec;
   end

   // Head record is gated so all trace outputs read 0 while the FIFO is empty
   always_comb begin
      head_rec      = tmem_q[trd_q[TW-1:0]];
      trace_valid   = ~tr_empty;
      trace_addr    = tr_empty ? '0 : head_rec.addr;
      trace_instr   = tr_empty ? '0 : head_rec.instr;
      trace_err     = ~tr_empty & head_rec.err;
      trace_is_addi = ~tr_empty & head_rec.is_addi;
      cnt_fetch     = cnt_fetch_q;
      cnt_addi      = cnt_addi_q;
      cnt_drop      = cnt_drop_q;
      pend_overflow = ovf_q;
      orphan_resp   = orph_q;
   end

endmodule

// File: tb/tb_scr1_imem_fetch_tracer.sv
// Scoreboard bench: the stimulus side runs a queue-based reference model and
// pushes expected trace records; a negedge monitor pops and compares them
// whenever the DUT hands a record to the consumer.
module tb_scr1_imem_fetch_tracer;

   localparam int PD   = 4;
   localparam int TD   = 8;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] instr;
      bit          err;
      bit          addi;
   } rec_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          imem_req = 1'b0, imem_req_ack = 1'b0;
   logic [31:0]   imem_addr = '0;
   logic [1:0]    imem_resp = '0;
   logic [31:0]   imem_rdata = '0;
   logic          cnt_clr = 1'b0;
   logic          trace_ready = 1'b0;
   logic          trace_valid, trace_err, trace_is_addi;
   logic [31:0]   trace_addr, trace_instr;
   logic [CW-1:0] cnt_fetch, cnt_addi, cnt_drop;
   logic          pend_overflow, orphan_resp;

   scr1_imem_fetch_tracer #(
      .PEND_DEPTH (PD),
      .TRACE_DEPTH(TD),
      .CNT_W      (CW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .imem_req     (imem_req),
      .imem_req_ack (imem_req_ack),
      .imem_addr    (imem_addr),
      .imem_resp    (imem_resp),
      .imem_rdata   (imem_rdata),
      .cnt_clr      (cnt_clr),
      .trace_valid  (trace_valid),
      .trace_ready  (trace_ready),
      .trace_addr   (trace_addr),
      .trace_instr  (trace_instr),
      .trace_err    (trace_err),
      .trace_is_addi(trace_is_addi),
      .cnt_fetch    (cnt_fetch),
      .cnt_addi     (cnt_addi),
      .cnt_drop     (cnt_drop),
      .pend_overflow(pend_overflow),
      .orphan_resp  (orphan_resp)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [31:0] pq[$];
   rec_t        exp_q[$];
   int          m_occ, m_fetch, m_addi, m_drop;
   bit          m_ovf, m_orph;

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_state();
      check("trace_valid", 72'(trace_valid), 72'(m_occ != 0));
      check("cnt_fetch", 72'(cnt_fetch), 72'(m_fetch));
      check("cnt_addi", 72'(cnt_addi), 72'(m_addi));
      check("cnt_drop", 72'(cnt_drop), 72'(m_drop));
      check("pend_overflow", 72'(pend_overflow), 72'(m_ovf));
      check("orphan_resp", 72'(orphan_resp), 72'(m_orph));
   endtask

   task automatic model_clear();
      pq.delete();
      exp_q.delete();
      m_occ = 0; m_fetch = 0; m_addi = 0; m_drop = 0;
      m_ovf = 0; m_orph = 0;
   endtask

   // One clock: check current state, drive inputs, predict effect of the edge.
   task automatic cycle(input bit rq, input bit ak, input logic [31:0] a,
                        input logic [1:0] rs, input logic [31:0] rd,
                        input bit rdy, input bit cl);
      rec_t r;
      int   occ;
      check_state();
      imem_req = rq; imem_req_ack = ak; imem_addr = a;
      imem_resp = rs; imem_rdata = rd; trace_ready = rdy; cnt_clr = cl;
      occ = m_occ - ((rdy && m_occ > 0) ? 1 : 0);
      if (rs != 2'b00) begin
         if (pq.size() == 0) m_orph = 1;
         else begin
            r.addr  = pq.pop_front();
            r.err   = (rs != 2'b01);
            r.instr = r.err ? 32'h0 : rd;
            r.addi  = !r.err && ((rd & 32'h0000_707F) == 32'h0000_0013);
            if (m_fetch < CMAX) m_fetch++;
            if (r.addi && m_addi < CMAX) m_addi++;
            if (occ < TD) begin exp_q.push_back(r); occ++; end
            else if (m_drop < CMAX) m_drop++;
         end
      end
      if (rq && ak) begin
         if (pq.size() < PD) pq.push_back(a);
         else m_ovf = 1;
      end
      if (cl) begin
         m_fetch = 0; m_addi = 0; m_drop = 0; m_ovf = 0; m_orph = 0;
      end
      m_occ = occ;
      @(posedge clk); #1;
   endtask

   task automatic idle(input bit rdy);
      cycle(0, 0, 32'h0, 2'b00, 32'h0, rdy, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      imem_req = 0; imem_req_ack = 0; imem_resp = 2'b00; cnt_clr = 0; trace_ready = 0;
      model_clear();
      #2;
      check("rst_outputs",
            {trace_valid, trace_addr, trace_instr, trace_err, trace_is_addi,
             pend_overflow, orphan_resp},
            72'h0);
      check("rst_counters", 72'({cnt_fetch, cnt_addi, cnt_drop}), 72'h0);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Monitor: compare each record the consumer takes against the scoreboard
   always @(negedge clk) begin
      if (!rst && trace_valid && trace_ready) begin
         if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL trace_rec: got unexpected record addr %0h, expected none", trace_addr);
         end else begin
            rec_t e;
            e = exp_q.pop_front();
            check("trace_rec", {trace_addr, trace_instr, trace_err, trace_is_addi},
                  {e.addr, e.instr, e.err, e.addi});
         end
      end
   end

   initial begin
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // 1: single ADDI fetch, visible the cycle after the response
      cycle(1, 1, 32'h200, 2'b00, 32'h0, 0, 0);
      idle(0);
      cycle(0, 0, 32'h0, 2'b01, 32'h0010_0093, 0, 0);
      check("t1_addr", 72'(trace_addr), 72'h200);
      check("t1_instr", 72'(trace_instr), 72'h0010_0093);
      check("t1_addi", 72'(trace_is_addi), 72'h1);
      check("t1_cnt", 72'({cnt_fetch, cnt_addi}), 72'({4'd1, 4'd1}));
      idle(1);

      // 2: back-to-back accepts, ordered responses, second is not ADDI
      cycle(1, 1, 32'h100, 2'b00, 32'h0, 1, 0);
      cycle(1, 1, 32'h104, 2'b00, 32'h0, 1, 0);
      cycle(0, 0, 32'h0, 2'b01, 32'h0000_0013, 1, 0);
      cycle(0, 0, 32'h0, 2'b01, 32'h0000_2013, 1, 0);
      idle(1); idle(1);
      check("t2_cnt", 72'({cnt_fetch, cnt_addi}), 72'({4'd3, 4'd2}));

      // 3: error responses (10 and 11) with ADDI-looking data
      cycle(1, 1, 32'h300, 2'b00, 32'h0, 0, 0);
      cycle(0, 0, 32'h0, 2'b10, 32'h0010_0093, 0, 0);
      check("t3_err", 72'({trace_err, trace_is_addi, trace_instr}), 72'({1'b1, 1'b0, 32'h0}));
      cycle(1, 1, 32'h304, 2'b00, 32'h0, 1, 0);
      cycle(0, 0, 32'h0, 2'b11, 32'h0010_0093, 1, 0);
      idle(1); idle(1);

      // 4: nine ADDI records with consumer stalled, then drain
      cycle(0, 0, 32'h0, 2'b00, 32'h0, 0, 1);
      for (int i = 0; i < 9; i++) begin
         cycle(1, 1, 32'h1000 + 32'(i * 4), 2'b00, 32'h0, 0, 0);
         cycle(0, 0, 32'h0, 2'b01, 32'h0050_0513, 0, 0);
      end
      check("t4_drop", 72'(cnt_drop), 72'h1);
      check("t4_addi", 72'(cnt_addi), 72'h9);
      for (int i = 0; i < 8; i++) idle(1);
      check("t4_empty", 72'(trace_valid), 72'h0);

      // 5: orphan response, pending overflow, then clear
      cycle(0, 0, 32'h0, 2'b01, 32'h13, 0, 0);
      for (int i = 0; i < 5; i++) cycle(1, 1, 32'h2000 + 32'(i * 4), 2'b00, 32'h0, 0, 0);
      check("t5_flags", 72'({pend_overflow, orphan_resp, trace_valid}), 72'({1'b1, 1'b1, 1'b0}));
      cycle(0, 0, 32'h0, 2'b00, 32'h0, 0, 1);
      check("t5_clr", 72'({pend_overflow, orphan_resp, cnt_fetch, cnt_addi, cnt_drop}), 72'h0);
      // accept + response with pending full: both succeed, pairs with old head
      cycle(1, 1, 32'h2100, 2'b01, 32'h13, 1, 0);
      idle(1); idle(1);

      // 6: reset with fetches outstanding; next response is an orphan
      do_reset();
      cycle(1, 1, 32'h400, 2'b00, 32'h0, 0, 0);
      cycle(1, 1, 32'h404, 2'b00, 32'h0, 0, 0);
      do_reset();
      cycle(0, 0, 32'h0, 2'b01, 32'h13, 0, 0);
      check("t6_orphan", 72'({orphan_resp, trace_valid}), 72'({1'b1, 1'b0}));

      // Random traffic with saturation, clears and occasional reset
      begin
         int rdy_pct;
         rdy_pct = 50;
         for (int c = 0; c < 3000; c++) begin
            logic [31:0] rd;
            logic [1:0]  rs;
            if (c % 200 == 0) rdy_pct = $urandom_range(0, 100);
            if ($urandom_range(0, 599) == 0) begin
               do_reset();
            end else begin
               rd = $urandom;
               if ($urandom_range(0, 1) == 0) rd = (rd & 32'hFFFF_8F80) | 32'h0000_0013;
               rs = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
               if ($urandom_range(0, 3) == 0) rs = 2'b01;
               cycle($urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, $urandom, rs, rd,
                     $urandom_range(1, 100) <= rdy_pct, $urandom_range(0, 299) == 0);
            end
         end
      end

      for (int i = 0; i < 12; i++) idle(1);
      check("final_drain", 72'(exp_q.size()), 72'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
